// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // Loaded/stored data is always one byte.
  localparam int DATA_W = 8;
  // Destination register index width.
  localparam int RIDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_fwd_buf.sv
// One-entry store buffer with an address match compare.
// Written on every store issue; a load looking up a matching address
// gets the buffered byte without going to memory.
module lsu_fwd_buf
  import lsu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] data_q;

  // Capture the most recent store; reset empties the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      addr_q  <= wr_addr;
      data_q  <= wr_data;
    end
  end

  assign hit      = valid_q && (addr_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/load_store_unit.sv
// Byte load/store unit between decode, data memory and the register file.
// Loads are unsigned bytes; a load that sees no memory response within
// TIMEOUT wait cycles writes back 8'h00 and sets the sticky err_timeout.
// Optional feature macro: LSU_STFWD_EN adds a one-entry store buffer that
// serves matching loads without a memory access.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is high only in IDLE; the requester holds
// its request fields stable until the transfer. Memory strobes (mem_req,
// mem_en) are single-cycle pulses with no back-pressure.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RIDX_W-1:0] req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic [RIDX_W-1:0] wr_addr,
  output logic [DATA_W-1:0] lbu_take,
  output logic              busy,
  output logic              err_timeout,
  output lsu_state_t        state_dbg
);

  // Last WAIT count value; reaching it without a response abandons the load.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic              is_store_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RIDX_W-1:0] rd_q;
  logic [7:0]        cnt_q;
  logic [DATA_W-1:0] take_q;
  logic [RIDX_W-1:0] wr_addr_q;
  logic              err_q;
  logic              fwd_q;

  logic              xfer;
  logic              fwd_hit;
  logic              fwd_take;
  logic [DATA_W-1:0] fwd_data;
  logic              wb_load;
  logic [DATA_W-1:0] wb_data;
  logic              to_hit;

  assign xfer = req_valid && req_ready;

`ifdef LSU_STFWD_EN
  logic [AW-1:0] lookup_addr;

  // Look up the incoming address while idle, the latched one afterwards.
  assign lookup_addr = (state_q == IDLE) ? req_addr : addr_q;

  lsu_fwd_buf #(.AW(AW)) u_fwd_buf (
    .clk         (clk),
    .reset       (reset),
    .wr_en       ((state_q == ISSUE) && is_store_q),
    .wr_addr     (addr_q),
    .wr_data     (wdata_q),
    .lookup_addr (lookup_addr),
    .hit         (fwd_hit),
    .hit_data    (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  // A forwarded load skips ISSUE and parks for one cycle in WAIT, where
  // memory responses are ignored, so write-back lands one cycle early.
  assign fwd_take = xfer && !req_is_store && fwd_hit;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and write-back data selection.
  always_comb begin
    state_d = state_q;
    wb_load = 1'b0;
    wb_data = '0;
    to_hit  = 1'b0;
    case (state_q)
      IDLE:  if (req_valid) state_d = fwd_take ? WAIT : ISSUE;
      ISSUE: state_d = is_store_q ? IDLE : WAIT;
      WAIT: begin
        if (fwd_q) begin
          state_d = WB;
          wb_load = 1'b1;
          wb_data = fwd_data;
        end else if (mem_rvalid) begin
          state_d = WB;
          wb_load = 1'b1;
          wb_data = mem_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d = WB;
          wb_load = 1'b1;
          to_hit  = 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, loaded only on a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      fwd_q      <= 1'b0;
    end else if (xfer) begin
      is_store_q <= req_is_store;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      rd_q       <= req_rd;
      fwd_q      <= fwd_take;
    end
  end

  // Wait-cycle counter, cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_q <= '0;
    else if (state_q == WAIT)  cnt_q <= cnt_q + 8'd1;
    else                       cnt_q <= '0;
  end

  // Write-back registers change only on entry to WB, so they hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_q    <= '0;
      wr_addr_q <= '0;
    end else if (wb_load) begin
      take_q    <= wb_data;
      wr_addr_q <= rd_q;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (to_hit) err_q <= 1'b1;
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = !req_ready;
  assign mem_req     = (state_q == ISSUE);
  assign mem_we      = mem_req && is_store_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_en      = (state_q == WB);
  assign wr_addr     = wr_addr_q;
  assign lbu_take    = take_q;
  assign err_timeout = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory
// requests and write-backs (with the cycle they must appear) into queues;
// a negedge monitor pops and compares whenever mem_req or mem_en is high.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW    = 8;
  localparam int TO    = 16;
  localparam int MEM_W = 16 + 1 + AW + 8;
  localparam int WB_W  = 16 + 2 + 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_is_store;
  logic [AW-1:0] req_addr;
  logic [7:0] req_wdata;
  logic [1:0] req_rd;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic mem_rvalid;
  logic [7:0] mem_rdata;
  logic mem_en;
  logic [1:0] wr_addr;
  logic [7:0] lbu_take;
  logic busy, err_timeout;
  lsu_state_t state_dbg;

  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  load_store_unit #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .wr_addr(wr_addr), .lbu_take(lbu_take),
    .busy(busy), .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [MEM_W-1:0] exp_mem_q[$];
  logic [WB_W-1:0]  exp_wb_q[$];
  logic [MEM_W-1:0] e_mem;
  logic [WB_W-1:0]  e_wb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got strobe at cycle %0d expected none", name, cyc);
  endtask

  // Monitor: every strobe must match the head of its expected queue.
  always @(negedge clk) begin
    if (mem_req || mem_en) check("req_en_exclusive", {63'd0, mem_req & mem_en}, 64'd0);
    if (mem_req) begin
      if (exp_mem_q.size() == 0) unexpected("mem_req_unexpected");
      else begin
        e_mem = exp_mem_q.pop_front();
        check("mem_req {cyc,we,addr,wdata}", {31'd0, cyc, mem_we, mem_addr, mem_wdata}, {31'd0, e_mem});
      end
    end
    if (mem_en) begin
      if (exp_wb_q.size() == 0) unexpected("mem_en_unexpected");
      else begin
        e_wb = exp_wb_q.pop_front();
        check("mem_en {cyc,wr_addr,lbu_take}", {38'd0, cyc, wr_addr, lbu_take}, {38'd0, e_wb});
      end
    end
  end

  // ---------------- memory responder ----------------
  logic       resp_en;
  int         resp_delay;
  logic [7:0] resp_data;
  int         stray_cnt  = 0;
  int         stray_done = 0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done = stray_cnt;
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hEE;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end else if (mem_req && !mem_we && resp_en) begin
        @(negedge clk);
        repeat (resp_delay) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = resp_data;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic st, input logic [AW-1:0] a, input logic [7:0] d,
                      input logic [1:0] rd, output logic [15:0] n);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) unexpected("send_ready_timeout");
    req_valid    = 1'b1;
    req_is_store = st;
    req_addr     = a;
    req_wdata    = d;
    req_rd       = rd;
    @(posedge clk);
    #1;
    n = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int guard = 0;
    @(negedge clk);
    while (!(req_ready && exp_mem_q.size() == 0 && exp_wb_q.size() == 0) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("drain_within_bound", {63'd0, req_ready && exp_mem_q.size() == 0 && exp_wb_q.size() == 0}, 64'd1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] n;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    resp_en = 1'b1; resp_delay = 0; resp_data = 8'h00;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_err", err_timeout, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Load 0x10 -> rd 1, memory answers A5 in the first WAIT cycle.
    resp_delay = 0; resp_data = 8'hA5;
    send(1'b0, 8'h10, 8'h00, 2'b01, n);
    exp_mem_q.push_back({n, 1'b0, 8'h10, 8'h00});
    exp_wb_q.push_back({n + 16'd2, 2'b01, 8'hA5});
    wait_quiet();
    check("err_after_good_load", err_timeout, 0);

    // Store 3C to 0x20: one mem_req, ready returns the cycle after.
    send(1'b1, 8'h20, 8'h3C, 2'b00, n);
    exp_mem_q.push_back({n, 1'b1, 8'h20, 8'h3C});
    @(negedge clk);
    check("store_ready_low", req_ready, 0);
    @(negedge clk);
    check("store_ready_back", req_ready, 1);
    wait_quiet();

    // Load with the response three cycles late.
    resp_delay = 3; resp_data = 8'h5A;
    send(1'b0, 8'h11, 8'h00, 2'b10, n);
    exp_mem_q.push_back({n, 1'b0, 8'h11, 8'h00});
    exp_wb_q.push_back({n + 16'd5, 2'b10, 8'h5A});
    wait_quiet();
    check("hold_lbu_take", lbu_take, 8'h5A);
    check("hold_wr_addr", wr_addr, 2'b10);

    // Timeout: no response, 16 WAIT cycles then 00 with err set.
    resp_en = 1'b0;
    send(1'b0, 8'h33, 8'h00, 2'b11, n);
    exp_mem_q.push_back({n, 1'b0, 8'h33, 8'h00});
    exp_wb_q.push_back({n + 16'd17, 2'b11, 8'h00});
    wait_quiet();
    check("err_set_on_timeout", err_timeout, 1);
    resp_en = 1'b1;

    // A later good load does not clear the sticky flag.
    resp_delay = 1; resp_data = 8'hC3;
    send(1'b0, 8'h12, 8'h00, 2'b00, n);
    exp_mem_q.push_back({n, 1'b0, 8'h12, 8'h00});
    exp_wb_q.push_back({n + 16'd3, 2'b00, 8'hC3});
    wait_quiet();
    check("err_sticky", err_timeout, 1);

    // Stray response while idle must be ignored.
    stray_cnt++;
    repeat (4) @(negedge clk);
    check("stray_idle_ready", req_ready, 1);
    check("stray_lbu_hold", lbu_take, 8'hC3);

    // Store 77 to 0x40 then load 0x40 into rd 3.
    send(1'b1, 8'h40, 8'h77, 2'b00, n);
    exp_mem_q.push_back({n, 1'b1, 8'h40, 8'h77});
    wait_quiet();
    resp_delay = 0; resp_data = 8'h99;
    send(1'b0, 8'h40, 8'h00, 2'b11, n);
`ifdef LSU_STFWD_EN
    exp_wb_q.push_back({n + 16'd1, 2'b11, 8'h77});
    wait_quiet();
    check("fwd_lbu_take", lbu_take, 8'h77);
`else
    exp_mem_q.push_back({n, 1'b0, 8'h40, 8'h00});
    exp_wb_q.push_back({n + 16'd2, 2'b11, 8'h99});
    wait_quiet();
    check("nofwd_lbu_take", lbu_take, 8'h99);
`endif

    // Reset pulsed during WAIT, then a late response arrives.
    resp_en = 1'b0;
    send(1'b0, 8'h55, 8'h00, 2'b01, n);
    exp_mem_q.push_back({n, 1'b0, 8'h55, 8'h00});
    @(negedge clk);
    @(negedge clk);
    check("in_wait_state", state_dbg, WAIT);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ready", req_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_mem_en", mem_en, 0);
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_err", err_timeout, 0);
    check("async_rst_lbu_take", lbu_take, 8'h00);
    check("async_rst_wr_addr", wr_addr, 2'b00);
    check("async_rst_mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    stray_cnt++;
    repeat (6) @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_lbu_take", lbu_take, 8'h00);
    check("post_rst_err", err_timeout, 0);

    check("mem_q_empty", exp_mem_q.size(), 0);
    check("wb_q_empty", exp_wb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
